grad_outlet_reader: RTL and testbench

Reads the concentration gradient produced at the outlets of the gradient-generator tree. The block steps a valve selector through the NUM_CH outlet channels and waits a programmable settle time on each. It then collects 2^AVG_LOG2 detector (ADC) samples over a req/valid handshake and emits one averaged result per channel. It sits between the fluidic netlist's outlet manifold and the host-side result logger, and it flags whether the measured gradient is monotonic.

---
 rtl/grad_outlet_reader.sv | 174 +++++++++++++++++
 tb/tb_grad_outlet_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_outlet_reader.sv
// grad_outlet_reader
//
// Scans the outlet channels of a gradient-generator tree. For each channel
// it selects the outlet valve, waits a programmable settle time, then
// collects 2^AVG_LOG2 detector samples and emits their truncated average.
// After the last channel it reports whether the measured gradient was
// non-increasing from channel 0 to channel NUM_CH-1.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin a scan (only looked at while idle)
//   abort           cancel a scan; back to idle next cycle, nothing emitted
//   settle_cycles   per-channel settle wait, captured when a scan starts
//   busy            scan in progress
//   ch_sel          valve select for the outlet being measured
//   adc_req/valid   detector handshake (see below)
//   adc_data        detector sample
//   res_valid       one-cycle pulse carrying res_ch / res_data
//   done            one-cycle pulse with the last channel's result
//   monotonic       outcome of the last completed scan
//
// Handshake: adc_req is held high for the whole sampling phase of a channel.
// A sample is taken on every rising edge where adc_req and adc_valid are both
// high; adc_valid while adc_req is low is ignored. adc_req drops the cycle
// after the final sample of a channel has been taken.
module grad_outlet_reader #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE_W = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                busy,
  output logic [CH_W-1:0]     ch_sel,
  output logic                adc_req,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [SAMPLE_W-1:0] res_data,
  output logic                done,
  output logic                monotonic
);

  localparam int ACC_W  = SAMPLE_W + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, EMIT} state_t;

  state_t              state, state_nxt;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SCNT_W-1:0]   samp_cnt;
  logic [ACC_W-1:0]    acc;
  logic [SAMPLE_W-1:0] prev_res;
  logic                mono_run;
  logic [CH_W-1:0]     ch_q;

  logic                accept;
  logic                settle_done;
  logic                last_ch;
  logic                emit;
  logic                res_ok;
  logic                mono_now;
  logic [SAMPLE_W-1:0] avg;

  // Dropping the low AVG_LOG2 bits is the truncating divide.
  assign avg         = acc[ACC_W-1 -: SAMPLE_W];
  assign accept      = (state == SAMPLE) && adc_valid;
  // Only evaluated in SETTLE, which is never entered with settle_q == 0.
  assign settle_done = (settle_cnt == settle_q - 1'b1);
  assign last_ch     = (ch_q == LAST_CH);
  // An abort in the EMIT cycle cancels the result as well.
  assign emit        = (state == EMIT) && !abort;
  // Channel 0 has no predecessor and always passes; ties pass.
  assign res_ok      = (ch_q == '0) || (avg <= prev_res);
  assign mono_now    = ((ch_q == '0) || mono_run) && res_ok;

  assign busy      = (state != IDLE);
  assign adc_req   = (state == SAMPLE);
  assign ch_sel    = ch_q;
  assign res_valid = emit;
  assign res_ch    = ch_q;
  assign res_data  = emit ? avg : '0;
  assign done      = emit && last_ch;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !abort)
          state_nxt = (settle_cycles == '0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (abort)            state_nxt = IDLE;
        else if (settle_done) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                                  state_nxt = IDLE;
        else if (accept && samp_cnt == LAST_SAMPLE) state_nxt = EMIT;
      end
      EMIT: begin
        if (abort || last_ch) state_nxt = IDLE;
        else                  state_nxt = (settle_q == '0) ? SAMPLE : SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_q   <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      acc        <= '0;
      prev_res   <= '0;
      mono_run   <= 1'b0;
      ch_q       <= '0;
      monotonic  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            settle_q   <= settle_cycles;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            acc        <= '0;
            ch_q       <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        SAMPLE: begin
          if (accept) begin
            acc      <= acc + ACC_W'(adc_data);
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (emit) begin
            prev_res   <= avg;
            mono_run   <= mono_now;
            acc        <= '0;
            samp_cnt   <= '0;
            settle_cnt <= '0;
            if (last_ch) begin
              monotonic <= mono_now;
              ch_q      <= '0;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Abort discards any partial channel; monotonic is left untouched.
      if (abort && state != IDLE) begin
        acc        <= '0;
        samp_cnt   <= '0;
        settle_cnt <= '0;
        ch_q       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_grad_outlet_reader.sv
// Testbench for grad_outlet_reader: directed scans with a detector responder,
// a scan-level reference model feeding an expected-result queue, one compare
// process, and literal expectations for each scenario.
module tb_grad_outlet_reader;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 12;
  localparam int AVG_LOG2 = 2;
  localparam int SETTLE_W = 16;
  localparam int CH_W     = 2;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int EW       = 1 + CH_W + SAMPLE_W;
  localparam logic [SAMPLE_W-1:0] JUNK = 12'h5A5;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                busy;
  logic [CH_W-1:0]     ch_sel;
  logic                adc_req;
  logic                adc_valid = 1'b0;
  logic [SAMPLE_W-1:0] adc_data = '0;
  logic                res_valid;
  logic [CH_W-1:0]     res_ch;
  logic [SAMPLE_W-1:0] res_data;
  logic                done;
  logic                monotonic;

  always #5 clk = ~clk;

  grad_outlet_reader #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2), .SETTLE_W(SETTLE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .settle_cycles(settle_cycles), .busy(busy), .ch_sel(ch_sel),
    .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .done(done), .monotonic(monotonic)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0]       exp_q[$];      // {last, ch, avg}
  logic [SAMPLE_W-1:0] samp_q[$];     // detector samples still to deliver
  int                  res_data_log[$];
  int                  res_cyc_log[$];
  logic [SAMPLE_W-1:0] tbl [NUM_CH][NS];
  logic                exp_mono = 1'b0;
  logic                mono_due = 1'b0;
  int                  done_seen = 0;
  int                  stall = 1;
  logic                pend = 1'b0;
  int                  vcnt = 0;
  int                  start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic set_row(input int c, input int a0, input int a1, input int a2, input int a3);
    tbl[c][0] = SAMPLE_W'(a0);
    tbl[c][1] = SAMPLE_W'(a1);
    tbl[c][2] = SAMPLE_W'(a2);
    tbl[c][3] = SAMPLE_W'(a3);
  endtask

  task automatic prep_scan();
    int avg [NUM_CH];
    int sum;
    exp_mono = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      sum = 0;
      for (int s = 0; s < NS; s++) begin
        sum += int'(tbl[c][s]);
        samp_q.push_back(tbl[c][s]);
      end
      avg[c] = sum / NS;
      if (c > 0 && avg[c] > avg[c-1]) exp_mono = 1'b0;
      exp_q.push_back({1'(c == NUM_CH - 1), CH_W'(c), SAMPLE_W'(avg[c])});
    end
    res_data_log.delete();
    res_cyc_log.delete();
  endtask

  // ---------------- detector responder ----------------
  // Decides adc_valid/adc_data each negedge; a sample that met adc_req at the
  // following edge is retired at the next negedge. Stray strobes carry JUNK.
  always @(negedge clk) begin
    if (rst) begin
      adc_valid = 1'b0;
      adc_data  = '0;
      pend      = 1'b0;
      vcnt      = 0;
    end else begin
      if (pend && samp_q.size() > 0) void'(samp_q.pop_front());
      vcnt++;
      adc_valid = ((vcnt % stall) == 0);
      adc_data  = (adc_valid && adc_req && samp_q.size() > 0) ? samp_q[0] : JUNK;
      pend      = adc_valid && adc_req;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      mono_due = 1'b0;
    end else begin
      if (mono_due) begin
        chk("monotonic_model", monotonic, exp_mono);
        chk("busy_after_done", busy, 0);
        mono_due = 1'b0;
      end
      if (adc_req && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("ch_sel_in_sample", ch_sel, e[SAMPLE_W +: CH_W]);
      end
      if (res_valid) begin
        res_cyc_log.push_back(cyc);
        res_data_log.push_back(int'(res_data));
        if (exp_q.size() == 0) begin
          chk("unexpected_res_valid", res_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_ch", res_ch, e[SAMPLE_W +: CH_W]);
          chk("res_data", res_data, e[SAMPLE_W-1:0]);
          chk("done_with_res", done, e[EW-1]);
          if (e[EW-1]) begin
            mono_due = 1'b1;
            done_seen++;
          end
        end
      end else if (done) begin
        chk("done_without_res", done, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int st);
    @(posedge clk); #1;
    settle_cycles = SETTLE_W'(st);
    start = 1'b1;
    chk("busy_before_start", busy, 0);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("adc_req_after_start", adc_req, (st == 0));
  endtask

  task automatic wait_done(input int budget);
    int seen0 = done_seen;
    int n = 0;
    while (done_seen == seen0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("scan_completes", (done_seen != seen0), 1);
    @(negedge clk);
    @(posedge clk); #1;
    chk("samples_consumed", samp_q.size(), 0);
  endtask

  task automatic check_log(input int a0, input int a1, input int a2, input int a3, input logic mono);
    int lit [NUM_CH];
    lit[0] = a0; lit[1] = a1; lit[2] = a2; lit[3] = a3;
    chk("result_count", res_data_log.size(), NUM_CH);
    if (res_data_log.size() == NUM_CH)
      for (int c = 0; c < NUM_CH; c++) chk("literal_res", res_data_log[c], lit[c]);
    chk("literal_monotonic", monotonic, mono);
  endtask

  // With adc_valid tied high: channel c emits (c+1)*(settle + NS + 1) cycles after start.
  task automatic check_timing(input int st);
    if (res_cyc_log.size() == NUM_CH)
      for (int c = 0; c < NUM_CH; c++)
        chk("res_cycle", res_cyc_log[c] - start_cyc, (c + 1) * (st + NS + 1));
  endtask

  task automatic check_idle_outputs(input string tag, input logic mono);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_adc_req"}, adc_req, 0);
    chk({tag, "_ch_sel"}, ch_sel, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_ch"}, res_ch, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_monotonic"}, monotonic, mono);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected scan completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int found;
    rst = 1'b1; start = 1'b0; abort = 1'b0; settle_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset", 1'b0);
    rst = 1'b0;

    // Basic scan, detector always ready, settle 3.
    stall = 1;
    set_row(0, 4000, 4000, 4000, 4000);
    set_row(1, 3000, 3000, 3000, 3000);
    set_row(2, 1000, 1000, 1000, 1000);
    set_row(3, 0, 0, 0, 0);
    prep_scan();
    do_start(3);
    wait_done(200);
    check_log(4000, 3000, 1000, 0, 1'b1);
    check_timing(3);

    // Averaging / truncation / full-scale.
    set_row(0, 1, 2, 2, 2);
    set_row(1, 4095, 4095, 4095, 4095);
    set_row(2, 10, 11, 12, 13);
    set_row(3, 0, 0, 0, 3);
    prep_scan();
    do_start(2);
    wait_done(200);
    check_log(1, 4095, 11, 0, 1'b0);
    check_timing(2);

    // Stalled detector with stray strobes, and a start while busy.
    stall = 3;
    set_row(0, 400, 300, 200, 100);
    set_row(1, 70, 60, 50, 80);
    set_row(2, 9, 9, 9, 10);
    set_row(3, 1, 0, 0, 2);
    prep_scan();
    do_start(1);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; settle_cycles = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_log(250, 65, 9, 0, 1'b1);

    // Rising step between ch1 and ch2, then equal neighbours.
    stall = 1;
    set_row(0, 4000, 4000, 4000, 4000);
    set_row(1, 3000, 3000, 3000, 3000);
    set_row(2, 3500, 3500, 3500, 3500);
    set_row(3, 100, 100, 100, 100);
    prep_scan();
    do_start(1);
    wait_done(200);
    check_log(4000, 3000, 3500, 100, 1'b0);

    set_row(0, 2000, 2000, 2000, 2000);
    set_row(1, 2000, 2000, 2000, 2000);
    set_row(2, 1500, 1500, 1500, 1500);
    set_row(3, 1500, 1500, 1500, 1500);
    prep_scan();
    do_start(1);
    wait_done(200);
    check_log(2000, 2000, 1500, 1500, 1'b1);

    // start with abort in IDLE: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; settle_cycles = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", busy, 0);

    // Abort during ch2 sampling.
    set_row(0, 3000, 3000, 3000, 3000);
    set_row(1, 2000, 2000, 2000, 2000);
    set_row(2, 1000, 1000, 1000, 1000);
    set_row(3, 500, 500, 500, 500);
    prep_scan();
    do_start(2);
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge clk);
      if (adc_req && ch_sel == 2'd2) found = 1;
    end
    chk("reached_ch2_sample", found, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle_outputs("abort", 1'b1);
    chk("results_before_abort", res_data_log.size(), 2);
    exp_q.delete();
    samp_q.delete();
    repeat (5) @(posedge clk);

    // Rescan from ch0 with zero settle.
    set_row(0, 800, 800, 800, 800);
    set_row(1, 600, 600, 600, 600);
    set_row(2, 400, 400, 400, 400);
    set_row(3, 200, 200, 200, 200);
    prep_scan();
    do_start(0);
    wait_done(200);
    check_log(800, 600, 400, 200, 1'b1);
    check_timing(0);

    // Asynchronous reset in the middle of SETTLE.
    set_row(0, 5, 5, 5, 5);
    prep_scan();
    do_start(10);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst", 1'b0);
    exp_q.delete();
    samp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Recovery scan after reset.
    set_row(0, 7, 7, 7, 7);
    set_row(1, 7, 7, 7, 7);
    set_row(2, 7, 7, 7, 7);
    set_row(3, 7, 7, 7, 7);
    prep_scan();
    do_start(0);
    wait_done(200);
    check_log(7, 7, 7, 7, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
